controller: RTL
===============

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; there are no other clocks or resets.
REQ-002 Port list, in order:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- I_RdData  in  16  instruction memory read data, registered, one cycle after I_Addr
- I_Addr  out  7  instruction memory address (PC)
- D_Addr  out  8  data memory address
- D_WriteEn  out  1  data memory write enable
- MuxS  out  1  register-file write source: 1 = memory r_data, 0 = ALU_Out
- RegF_W_addr  out  4  register-file write address
- RegF_W_en  out  1  register-file write enable
- RegF_Ra_addr  out  4  read port A address
- RegF_Rb_addr  out  4  read port B address
- ALU_S  out  3  ALU function select
- IR  out  16  instruction register
- State  out  4  current state encoding, for debug

Function
REQ-003 Instruction opcode is IR[15:12]:
- NOOP = 0
- STORE = 1 (D_Addr = IR[11:4], Ra = IR[3:0])
- LOAD = 2 (D_Addr = IR[11:4], W_addr = IR[3:0])
- ADD = 3 (Ra = IR[11:8], Rb = IR[7:4], W_addr = IR[3:0])
- SUB = 4 (same fields as ADD)
- HALT = 5
- opcodes 6-15 execute as NOOP
REQ-004 States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
REQ-005 INIT: PC <= 0, IR <= 0; next state FETCH.
REQ-006 FETCH: I_Addr = PC; PC <= PC+1 at end of cycle; next state DECODE.
REQ-007 DECODE: IR <= I_RdData at end of cycle; next state is selected from I_RdData[15:12] (not from IR).
REQ-008 LOAD_A: drive D_Addr; all write enables 0; next state LOAD_B (covers registered data-memory latency).
REQ-009 LOAD_B: hold D_Addr; MuxS = 1; RegF_W_en = 1; RegF_W_addr = IR[3:0]; next state FETCH.
REQ-010 STORE: drive D_Addr; RegF_Ra_addr = IR[3:0]; D_WriteEn = 1 for exactly one cycle; next state FETCH.
REQ-011 ADD: ALU_S = 3'd1; SUB: ALU_S = 3'd2. Both: MuxS = 0, RegF_W_en = 1, Ra/Rb/W_addr from IR; next state FETCH.
REQ-012 NOOP: no enables asserted; next state FETCH.
REQ-013 HALT: all enables 0; remains in HALT until reset.
REQ-014 In every state not listed above as asserting it, each output is 0: D_WriteEn, RegF_W_en, MuxS, ALU_S, D_Addr and all register addresses. Outputs are decoded combinationally from State and IR.
REQ-015 PC is 7 bits and wraps 127 -> 0 with no flag.
REQ-016 Instruction latency is 3 cycles (FETCH, DECODE, one execute state), or 4 cycles for LOAD.
REQ-017 D_WriteEn and RegF_W_en are never asserted in the same cycle.

Reset
REQ-018 When reset is high at a rising edge, the next state is INIT, regardless of the current state, including mid-LOAD and HALT.
REQ-019 While in INIT: PC = 0, IR = 0 and all outputs are 0.
REQ-020 A write in progress when reset is sampled is dropped: no enable is asserted in the cycle after reset.

Structure
REQ-021 A shared package holds the opcode constants, the state enum (4-bit, with explicit encodings INIT = 0 through HALT = 9) and the ALU select constants (ADD = 1, SUB = 2).
REQ-022 The PC is a sub-module, program_counter, with clear, increment and a 7-bit output; the FSM and IR are in controller.

Verification
REQ-023 Reset, then I_RdData = 16'h2013 (LOAD D[1] -> R3) -> states FETCH, DECODE, LOAD_A, LOAD_B; D_Addr = 1 in LOAD_A and LOAD_B; RegF_W_en = 1 and MuxS = 1 only in LOAD_B; RegF_W_addr = 3.
REQ-024 I_RdData = 16'h3125 (ADD R1+R2 -> R5) -> ADD state, ALU_S = 1, Ra = 1, Rb = 2, W_addr = 5, MuxS = 0, RegF_W_en = 1 for one cycle; then 16'h4426 -> SUB state with ALU_S = 2.
REQ-025 I_RdData = 16'h1055 (STORE R5 -> D[5]) -> D_WriteEn = 1 for one cycle; D_Addr = 5; Ra = 5; RegF_W_en = 0.
REQ-026 I_RdData = 16'h5000 -> HALT held for 20 cycles, PC frozen, no enables; then reset pulse -> INIT, PC = 0.
REQ-027 Assert reset during LOAD_A -> next state INIT; RegF_W_en never asserted. Separately, preset PC = 127 and fetch -> PC wraps to 0. Separately, I_RdData = 16'hF000 -> NOOP path.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared definitions for the instruction controller: opcodes, FSM state
// encodings and ALU function selects.
package controller_pkg;

   // Instruction opcodes (IR[15:12]); 6-15 are treated as NOOP
   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_HALT  = 4'd5;

   // ALU function selects
   localparam logic [2:0] ALU_NONE = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;

   // Controller states; encodings are visible on the debug State port
   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_NOOP   = 4'd3,
      ST_LOAD_A = 4'd4,
      ST_LOAD_B = 4'd5,
      ST_STORE  = 4'd6,
      ST_ADD    = 4'd7,
      ST_SUB    = 4'd8,
      ST_HALT   = 4'd9
   } state_t;

   // Map an opcode to the first execute state of that instruction
   function automatic state_t exec_state(input logic [3:0] opcode);
      state_t s;
      case (opcode)
         OP_STORE: s = ST_STORE;
         OP_LOAD:  s = ST_LOAD_A;
         OP_ADD:   s = ST_ADD;
         OP_SUB:   s = ST_SUB;
         OP_HALT:  s = ST_HALT;
         default:  s = ST_NOOP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/controller_pc.sv
// 7-bit program counter with synchronous clear and increment; wraps 127 -> 0.
module program_counter
   import controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       incr,
   output logic [6:0] pc
);

   logic [6:0] pc_q;
   logic [6:0] pc_d;

   // Clear has priority over increment; natural 7-bit overflow gives the wrap
   always_comb begin
      pc_d = pc_q;
      if (clear) begin
         pc_d = 7'd0;
      end else if (incr) begin
         pc_d = pc_q + 7'd1;
      end
   end

   // PC register, zeroed on reset so INIT already shows PC = 0
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= 7'd0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/controller.sv
// Multi-cycle instruction controller: fetch/decode/execute FSM, instruction
// register and combinational decode of datapath control signals.
module controller
   import controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] I_RdData,
   output logic [6:0]  I_Addr,
   output logic [7:0]  D_Addr,
   output logic        D_WriteEn,
   output logic        MuxS,
   output logic [3:0]  RegF_W_addr,
   output logic        RegF_W_en,
   output logic [3:0]  RegF_Ra_addr,
   output logic [3:0]  RegF_Rb_addr,
   output logic [2:0]  ALU_S,
   output logic [15:0] IR,
   output logic [3:0]  State
);

   state_t      state_q;
   state_t      state_d;
   logic [15:0] ir_q;
   logic [15:0] ir_d;
   logic        pc_clear;
   logic        pc_incr;
   logic [6:0]  pc;

   program_counter u_pc (
      .clk   (clk),
      .reset (reset),
      .clear (pc_clear),
      .incr  (pc_incr),
      .pc    (pc)
   );

   // Next-state, IR load and PC control; decode uses the memory word
   // directly because IR only captures it at the end of DECODE
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      pc_clear = 1'b0;
      pc_incr  = 1'b0;
      case (state_q)
         ST_INIT: begin
            pc_clear = 1'b1;
            ir_d     = 16'd0;
            state_d  = ST_FETCH;
         end
         ST_FETCH: begin
            pc_incr = 1'b1;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            ir_d    = I_RdData;
            state_d = exec_state(I_RdData[15:12]);
         end
         ST_LOAD_A: state_d = ST_LOAD_B;
         ST_LOAD_B: state_d = ST_FETCH;
         ST_STORE:  state_d = ST_FETCH;
         ST_ADD:    state_d = ST_FETCH;
         ST_SUB:    state_d = ST_FETCH;
         ST_NOOP:   state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_INIT;
      endcase
   end

   // State and IR registers; reset always returns to INIT with IR cleared
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         ir_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Datapath controls decoded from the current state and IR; everything
   // defaults to zero so only the execute states assert anything
   always_comb begin
      D_Addr       = 8'd0;
      D_WriteEn    = 1'b0;
      MuxS         = 1'b0;
      RegF_W_addr  = 4'd0;
      RegF_W_en    = 1'b0;
      RegF_Ra_addr = 4'd0;
      RegF_Rb_addr = 4'd0;
      ALU_S        = ALU_NONE;
      case (state_q)
         ST_LOAD_A: begin
            D_Addr = ir_q[11:4];
         end
         ST_LOAD_B: begin
            D_Addr      = ir_q[11:4];
            MuxS        = 1'b1;
            RegF_W_en   = 1'b1;
            RegF_W_addr = ir_q[3:0];
         end
         ST_STORE: begin
            D_Addr       = ir_q[11:4];
            RegF_Ra_addr = ir_q[3:0];
            D_WriteEn    = 1'b1;
         end
         ST_ADD, ST_SUB: begin
            ALU_S        = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
            RegF_Ra_addr = ir_q[11:8];
            RegF_Rb_addr = ir_q[7:4];
            RegF_W_addr  = ir_q[3:0];
            RegF_W_en    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign I_Addr = pc;
   assign IR     = ir_q;
   assign State  = state_q;

endmodule
